multicycle_main_memory: RTL and testbench

- Parametrised successor to the uncached Main_Memory: split instruction/data storage behind a single request port with a configurable access latency and a busy/Done handshake.
- Sits between Control and the datapath; a later cache layer will front it unchanged.
- Adds illegal-request detection, address wrap-around and a busy indication.

---
 rtl/multicycle_main_memory.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_main_memory.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_memory.sv
// ---------------------------------------------------------------------------
// multicycle_main_memory
//
// Split instruction/data word memory behind a single request port with a
// configurable access latency. A request (exactly one of read/write) is
// captured in IDLE, held for LATENCY cycles in BUSY, completed at the end
// of BUSY, and acknowledged with a one-cycle Done pulse while in DONE.
// Simultaneous read+write in IDLE is rejected with a one-cycle err pulse.
// Addresses wrap modulo the selected array depth.
//
// Optional feature macro: MEM_WRITE_PROTECT_EN
//   When defined, instruction-array writes complete with normal timing but
//   are not committed; err pulses together with Done.
//
// Ports:
//   clk          in   1       system clock, rising edge
//   reset        in   1       synchronous, active-high reset
//   address      in   ADDR_W  word address
//   dataIn       in   DATA_W  write data
//   write        in   1       write request
//   read         in   1       read request
//   instruction  in   1       1 = instruction array, 0 = data array
//   dataOut      out  DATA_W  registered read data (held between reads)
//   Done         out  1       one-cycle completion pulse
//   busy         out  1       high while a request is in flight
//   err          out  1       one-cycle error pulse
// ---------------------------------------------------------------------------
module multicycle_main_memory #(
    parameter int DATA_W     = 13,
    parameter int ADDR_W     = 13,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              write,
    input  logic              read,
    input  logic              instruction,
    output logic [DATA_W-1:0] dataOut,
    output logic              Done,
    output logic              busy,
    output logic              err
);

    localparam int IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Storage (not affected by reset)
    logic [DATA_W-1:0] imem_r [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem_r [DMEM_DEPTH];

    // FSM and captured request
    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  counter_r;
    logic [CNT_W-1:0]  counter_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              op_write_r;
    logic              instr_r;

    // Registered outputs and their next values
    logic [DATA_W-1:0] data_out_r;
    logic              done_r;
    logic              busy_r;
    logic              err_r;
    logic              done_nxt_s;
    logic              busy_nxt_s;
    logic              err_nxt_s;

    // Control strobes
    logic              capture_s;
    logic              access_s;
    logic              imem_we_s;
    logic              dmem_we_s;
    logic              rd_en_s;
    logic [IMEM_AW-1:0] imem_idx_s;
    logic [DMEM_AW-1:0] dmem_idx_s;
    logic [DATA_W-1:0] rd_word_s;

    // Index is simply the low address bits: silent wrap-around
    assign imem_idx_s = addr_r[IMEM_AW-1:0];
    assign dmem_idx_s = addr_r[DMEM_AW-1:0];

    // State register and counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            counter_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            counter_r <= counter_nxt_s;
        end
    end

    // Next-state and output-next logic
    always_comb begin
        state_nxt_s   = state_r;
        counter_nxt_s = counter_r;
        capture_s     = 1'b0;
        access_s      = 1'b0;
        done_nxt_s    = 1'b0;
        busy_nxt_s    = busy_r;
        err_nxt_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (read ^ write) begin
                    capture_s     = 1'b1;
                    counter_nxt_s = CNT_LOAD;
                    busy_nxt_s    = 1'b1;
                    state_nxt_s   = ST_BUSY;
                end else if (read && write) begin
                    // Ambiguous request: reject without capturing anything
                    err_nxt_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (counter_r == {CNT_W{1'b0}}) begin
                    access_s    = 1'b1;
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = ST_DONE;
`ifdef MEM_WRITE_PROTECT_EN
                    if (op_write_r && instr_r) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = 1'b0;
                    end
`endif
                end else begin
                    counter_nxt_s = counter_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                // Requests presented here are deliberately ignored
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                counter_nxt_s = {CNT_W{1'b0}};
                busy_nxt_s    = 1'b0;
            end
        endcase
    end

    // Access decode: which array (if any) is written, or whether dataOut loads
`ifdef MEM_WRITE_PROTECT_EN
    assign imem_we_s = 1'b0;
`else
    assign imem_we_s = access_s & op_write_r & instr_r;
`endif
    assign dmem_we_s = access_s & op_write_r & ~instr_r;
    assign rd_en_s   = access_s & ~op_write_r;
    assign rd_word_s = instr_r ? imem_r[imem_idx_s] : dmem_r[dmem_idx_s];

    // Request capture register
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            op_write_r <= 1'b0;
            instr_r    <= 1'b0;
        end else if (capture_s) begin
            addr_r     <= address;
            wdata_r    <= dataIn;
            op_write_r <= write;
            instr_r    <= instruction;
        end
    end

    // Array writes; reset at the completion edge aborts the commit
    always_ff @(posedge clk) begin
        if (!reset && imem_we_s) begin
            imem_r[imem_idx_s] <= wdata_r;
        end
        if (!reset && dmem_we_s) begin
            dmem_r[dmem_idx_s] <= wdata_r;
        end
    end

    // Registered outputs; dataOut only changes on a completed read
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_r <= {DATA_W{1'b0}};
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (rd_en_s) begin
                data_out_r <= rd_word_s;
            end
            done_r <= done_nxt_s;
            busy_r <= busy_nxt_s;
            err_r  <= err_nxt_s;
        end
    end

    assign dataOut = data_out_r;
    assign Done    = done_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule

// File: tb/tb_multicycle_main_memory.sv
// ---------------------------------------------------------------------------
// Testbench for multicycle_main_memory: directed steps followed by random
// requests, all checked against an array-level reference model.
// ---------------------------------------------------------------------------
module tb_multicycle_main_memory;

    localparam int DW = 13;
    localparam int AW = 13;
    localparam int L  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic [DW-1:0] dataIn;
    logic          write;
    logic          read;
    logic          instruction;
    logic [DW-1:0] dataOut;
    logic          Done;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Reference model: contents plus "known" flags (arrays power up unknown)
    logic [DW-1:0] imem_m [256];
    logic [DW-1:0] dmem_m [256];
    bit            ik [256];
    bit            dk [256];
    logic [DW-1:0] dout_m;
    bit            dout_k;

    multicycle_main_memory #(
        .DATA_W(13), .ADDR_W(13), .IMEM_DEPTH(256), .DMEM_DEPTH(256), .LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .dataIn(dataIn),
        .write(write), .read(read), .instruction(instruction),
        .dataOut(dataOut), .Done(Done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dout(input string tag);
        if (dout_k) chk(tag, 16'(dataOut), 16'(dout_m));
    endtask

    task automatic junk();
        address     = 13'($urandom);
        dataIn      = 13'($urandom);
        instruction = 1'($urandom);
        write       = 1'($urandom);
        read        = 1'($urandom);
    endtask

    // One complete accepted request, checked cycle by cycle
    task automatic do_req(input bit instr, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] din);
        int  idx;
        bit  exp_err;
        @(negedge clk);
        instruction = instr; write = wr; read = !wr; address = addr; dataIn = din;
        for (int i = 0; i < L; i++) begin
            @(posedge clk); #1;
            chk("busy_inflight", 16'(busy), 16'd1);
            chk("done_inflight", 16'(Done), 16'd0);
            chk("err_inflight", 16'(err), 16'd0);
            chk_dout("dout_hold_busy");
            junk();
        end
        @(posedge clk); #1;
        idx = int'(addr) % 256;
        exp_err = 1'b0;
        if (wr) begin
            if (instr) begin
`ifdef MEM_WRITE_PROTECT_EN
                exp_err = 1'b1;
`else
                imem_m[idx] = din; ik[idx] = 1'b1;
`endif
            end else begin
                dmem_m[idx] = din; dk[idx] = 1'b1;
            end
        end else begin
            if (instr) begin
                dout_m = imem_m[idx]; dout_k = ik[idx];
            end else begin
                dout_m = dmem_m[idx]; dout_k = dk[idx];
            end
        end
        chk("done_pulse", 16'(Done), 16'd1);
        chk("busy_done", 16'(busy), 16'd0);
        chk("err_done", 16'(err), 16'(exp_err));
        chk_dout("dout_done");
        junk();
        @(posedge clk); #1;
        chk("done_drop", 16'(Done), 16'd0);
        chk("busy_after", 16'(busy), 16'd0);
        chk("err_after", 16'(err), 16'd0);
        chk_dout("dout_after");
        read = 1'b0; write = 1'b0;
    endtask

    // Simultaneous read+write in IDLE: rejected
    task automatic do_both(input logic [AW-1:0] addr);
        @(negedge clk);
        read = 1'b1; write = 1'b1; address = addr; dataIn = 13'($urandom);
        instruction = 1'($urandom);
        @(posedge clk); #1;
        chk("both_err", 16'(err), 16'd1);
        chk("both_busy", 16'(busy), 16'd0);
        chk("both_done", 16'(Done), 16'd0);
        read = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        chk("both_err_drop", 16'(err), 16'd0);
        chk("both_busy2", 16'(busy), 16'd0);
        chk("both_done2", 16'(Done), 16'd0);
        chk_dout("both_dout");
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; instruction = 1'b0;
        address = 13'd0; dataIn = 13'd0;
        for (int i = 0; i < 256; i++) begin ik[i] = 1'b0; dk[i] = 1'b0; end
        dout_m = 13'd0; dout_k = 1'b1;

        // 1. reset, then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 16'(dataOut), 16'd0);
        chk("rst_done", 16'(Done), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_done", 16'(Done), 16'd0);
            chk("idle_busy", 16'(busy), 16'd0);
            chk("idle_err", 16'(err), 16'd0);
            chk("idle_dout", 16'(dataOut), 16'd0);
        end

        // 2. data write/read, instruction array kept distinct
        do_req(1'b1, 1'b1, 13'd0, 13'h0555);
        do_req(1'b0, 1'b1, 13'd0, 13'h10F0);
        do_req(1'b0, 1'b0, 13'd0, 13'h0000);
        chk("dmem0_read", 16'(dataOut), 16'h10F0);
        do_req(1'b1, 1'b0, 13'd0, 13'h0000);

        // 3. wrap-around
        do_req(1'b0, 1'b1, 13'd300, 13'h0ABC);
        do_req(1'b0, 1'b0, 13'd44, 13'h0000);
        chk("wrap_read", 16'(dataOut), 16'h0ABC);

        // 4. simultaneous read+write leaves array alone
        do_both(13'd44);
        do_req(1'b0, 1'b0, 13'd44, 13'h0000);

        // 5. reset during a write aborts it
        do_req(1'b0, 1'b1, 13'd5, 13'h0777);
        @(negedge clk);
        write = 1'b1; read = 1'b0; instruction = 1'b0; address = 13'd5; dataIn = 13'h1FFF;
        @(posedge clk); #1;
        chk("abort_busy", 16'(busy), 16'd1);
        write = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        dout_m = 13'd0; dout_k = 1'b1;
        chk("abort_busy_clr", 16'(busy), 16'd0);
        chk("abort_dout", 16'(dataOut), 16'd0);
        for (int i = 0; i < L + 2; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 16'(Done), 16'd0);
            chk("abort_no_busy", 16'(busy), 16'd0);
        end
        do_req(1'b0, 1'b0, 13'd5, 13'h0000);
        chk("abort_read", 16'(dataOut), 16'h0777);

        // 6. instruction write (protected or committed depending on build)
        do_req(1'b1, 1'b1, 13'd7, 13'h0042);
        do_req(1'b1, 1'b1, 13'd7, 13'h0123);
        do_req(1'b1, 1'b0, 13'd7, 13'h0000);

        // Random requests against the model
        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] a;
            a = 13'($urandom) & 13'h1F0F;
            if ($urandom_range(0, 9) == 0) begin
                do_both(a);
            end else begin
                do_req(1'($urandom), 1'($urandom), a, 13'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
